dla_xbar_config_beat_tx: RTL and testbench
==========================================

Name: dla_xbar_config_beat_tx

Overview:
- Transmit end of the crossbar configuration stream.
- Accepts one complete xbar configuration packet in parallel, as the packed config-packet layout consumed by the xbar config handler FSM.
- Serializes it into CONFIG_BEAT_COUNT beats of CONFIG_DATA_WIDTH bits on a valid/ready stream, with a last flag.
- Sits between the DLA config network / CSR packet assembler and the xbar config input.

Parameters:
- CONFIG_DATA_WIDTH, 32: width of one config beat.
- CONFIG_BEAT_COUNT, 4: beats per packet; legal range is 1 or more.
- CONFIG_BEAT_COUNTER_WIDTH, $clog2(CONFIG_BEAT_COUNT)+1: width of the beat index / counter.

Ports:
- clk  in  1  sole clock.
- i_areset  in  1  asynchronous active-high reset.
- i_flush  in  1  synchronous abort; returns the block to IDLE.
- i_pkt_valid  in  1  parallel packet valid.
- o_pkt_ready  out  1  packet accept.
- i_pkt_data  in  CONFIG_DATA_WIDTH*CONFIG_BEAT_COUNT  packed config packet; pi_opt_fields in the LSBs, odcount_fields in the MSBs.
- o_beat_valid  out  1  beat valid.
- i_beat_ready  in  1  downstream (xbar config handler) ready.
- o_beat_data  out  CONFIG_DATA_WIDTH  current beat.
- o_beat_last  out  1  high on the final beat of a packet.
- o_beat_index  out  CONFIG_BEAT_COUNTER_WIDTH  index of the current beat, 0..CONFIG_BEAT_COUNT-1.
- o_busy  out  1  high while a packet is being transmitted.

Behaviour:
- Clock and reset: one clock, clk. Reset i_areset is asynchronous and active-high.
- Reset values: state=IDLE; o_beat_valid=0; o_beat_last=0; o_beat_index=0; o_beat_data=0; o_busy=0. o_pkt_ready=1 once reset deasserts.
- Beat order:
  - Beat k carries i_pkt_data[(k+1)*CONFIG_DATA_WIDTH-1 : k*CONFIG_DATA_WIDTH].
  - Beat 0 = pi output fields, then kernel fields 1..NUMBER_OF_AUX_KERNELS_ONLY, then idcount, and odcount last.
  - The receiver reassembles into its packed config_pkt in this order.
- Storage: the packet is captured into a CONFIG_DATA_WIDTH*CONFIG_BEAT_COUNT shift register on accept.
  - The shift register shifts right by CONFIG_DATA_WIDTH on each beat handshake.
  - o_beat_data is its low word (a registered output).
- State IDLE:
  - o_pkt_ready=1, o_beat_valid=0.
  - On i_pkt_valid: capture, set index=0, and go to SEND.
  - o_beat_valid rises the next cycle. Latency from packet accept to first beat valid is 1 cycle.
- State SEND:
  - o_beat_valid=1; o_busy=1; o_beat_last = (index==CONFIG_BEAT_COUNT-1).
  - Beat handshake = o_beat_valid & i_beat_ready.
  - On a handshake that is not the last beat: shift, index+1.
  - On a handshake of the last beat: if i_pkt_valid, capture the new packet, set index=0 and stay in SEND (zero-bubble back-to-back). Otherwise go to IDLE.
- o_pkt_ready = (state==IDLE) | (state==SEND & o_beat_last & i_beat_ready). This is a combinational path from i_beat_ready and is accepted as such.
- Stream rules:
  - While o_beat_valid=1 and i_beat_ready=0, o_beat_data, o_beat_last and o_beat_index stay stable.
  - o_beat_valid never drops without a handshake, except on i_flush or reset.
- Throughput: one beat per cycle under continuous ready. N-beat packets sent back-to-back occupy exactly N cycles each.
- CONFIG_BEAT_COUNT=1: every beat has o_beat_last=1, index is always 0, and the back-to-back rule applies on every handshake.
- i_flush:
  - Has priority over every other event, including a simultaneous packet accept.
  - Returns to IDLE, clears o_beat_valid, o_beat_last and the index, and sets o_pkt_ready=0 that cycle.
  - A partially sent packet is discarded; the receiver relies on its own resync.
- Reset mid-packet: all outputs go immediately to their reset values. No partial beat is re-sent after reset.
- Index counter: never exceeds CONFIG_BEAT_COUNT-1. No wrap-around is reachable in legal operation.

Test Plan:
- Single packet, N=4, W=32, data 0x44444444_33333333_22222222_11111111, ready always 1 → beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles T+1..T+4; last only on the 4th; index 0..3; o_busy high for those 4 cycles.
- Backpressure: ready low for 3 cycles during beat 1 → beat 1 data, index and last are held stable; total packet completes at T+7 with no duplicate or lost beat.
- Back-to-back packets A then B, i_pkt_valid held high → o_pkt_ready pulses in the cycle of A's last handshake; B beat 0 appears the next cycle; 8 beats in 8 cycles.
- N=1 parameterization, three packets 0xA, 0xB, 0xC, ready=1 → three consecutive beats, each with last=1 and index=0.
- i_flush asserted after beat 1 of 4 → o_beat_valid=0 the next cycle, state IDLE; next packet 0x...55 starts at index 0 with correct data.
- i_areset pulse asynchronously mid-beat 2 → o_beat_valid and o_busy drop without a clock edge; after release, o_pkt_ready=1 and the next packet is sent cleanly.

Source files
------------

// File: rtl/dla_xbar_config_beat_tx.sv
// Transmit end of the xbar configuration stream: takes one packed config packet
// and serializes it LSB word first into valid/ready beats tagged with index and last.
module dla_xbar_config_beat_tx #(
    parameter int CONFIG_DATA_WIDTH         = 32,
    parameter int CONFIG_BEAT_COUNT         = 4,
    parameter int CONFIG_BEAT_COUNTER_WIDTH = $clog2(CONFIG_BEAT_COUNT) + 1
) (
    input  logic                                          clk,
    input  logic                                          i_areset,
    input  logic                                          i_flush,
    input  logic                                          i_pkt_valid,
    output logic                                          o_pkt_ready,
    input  logic [CONFIG_DATA_WIDTH*CONFIG_BEAT_COUNT-1:0] i_pkt_data,
    output logic                                          o_beat_valid,
    input  logic                                          i_beat_ready,
    output logic [CONFIG_DATA_WIDTH-1:0]                  o_beat_data,
    output logic                                          o_beat_last,
    output logic [CONFIG_BEAT_COUNTER_WIDTH-1:0]          o_beat_index,
    output logic                                          o_busy
);

    localparam int PW = CONFIG_DATA_WIDTH * CONFIG_BEAT_COUNT;
    localparam int CW = CONFIG_BEAT_COUNTER_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(CONFIG_BEAT_COUNT - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0] r_index, w_index_nxt;
    logic          w_last;
    logic          w_beat_hs;
    logic          w_pkt_ready;

    assign w_last    = (r_state == S_SEND) && (r_index == LAST_IDX);
    assign w_beat_hs = (r_state == S_SEND) && i_beat_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_index_nxt = r_index;
        w_pkt_ready = 1'b0;
        // Flush wins over everything, including an accept in the same cycle.
        if (i_flush) begin
            w_state_nxt = S_IDLE;
            w_index_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_pkt_ready = 1'b1;
                    if (i_pkt_valid) begin
                        w_shift_nxt = i_pkt_data;
                        w_index_nxt = '0;
                        w_state_nxt = S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_beat_hs) begin
                        if (!w_last) begin
                            w_shift_nxt = r_shift >> CONFIG_DATA_WIDTH;
                            w_index_nxt = r_index + CW'(1);
                        end else begin
                            // Last beat leaving: reload in place for zero-bubble back-to-back.
                            w_pkt_ready = 1'b1;
                            if (i_pkt_valid) begin
                                w_shift_nxt = i_pkt_data;
                                w_index_nxt = '0;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_areset) begin
        if (i_areset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_index <= w_index_nxt;
        end
    end

    assign o_pkt_ready  = w_pkt_ready & ~i_areset;
    assign o_beat_valid = (r_state == S_SEND);
    assign o_busy       = (r_state == S_SEND);
    assign o_beat_last  = w_last;
    assign o_beat_index = r_index;
    assign o_beat_data  = r_shift[CONFIG_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_dla_xbar_config_beat_tx.sv
// Bench for dla_xbar_config_beat_tx: directed scenarios plus random traffic,
// checked against a queue of expected beats built from each accepted packet.
module tb_dla_xbar_config_beat_tx;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk;
    logic           areset, flush, pkt_valid, pkt_ready;
    logic [W*N-1:0] pkt_data;
    logic           beat_valid, beat_ready, beat_last, busy;
    logic [W-1:0]   beat_data;
    logic [2:0]     beat_idx;

    logic       f1, p1_valid, p1_ready, b1_valid, b1_ready, b1_last, b1_busy;
    logic [7:0] p1_data, b1_data;
    logic [0:0] b1_idx;

    int n_cmp = 0;
    int n_err = 0;
    int rx_cnt = 0;
    int busy_cyc = 0;
    int r0, b0;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        logic [2:0]   i;
    } beat_t;
    beat_t q[$];

    dla_xbar_config_beat_tx #(.CONFIG_DATA_WIDTH(W), .CONFIG_BEAT_COUNT(N)) u_dut (
        .clk(clk), .i_areset(areset), .i_flush(flush),
        .i_pkt_valid(pkt_valid), .o_pkt_ready(pkt_ready), .i_pkt_data(pkt_data),
        .o_beat_valid(beat_valid), .i_beat_ready(beat_ready), .o_beat_data(beat_data),
        .o_beat_last(beat_last), .o_beat_index(beat_idx), .o_busy(busy));

    dla_xbar_config_beat_tx #(.CONFIG_DATA_WIDTH(8), .CONFIG_BEAT_COUNT(1)) u_dut1 (
        .clk(clk), .i_areset(areset), .i_flush(f1),
        .i_pkt_valid(p1_valid), .o_pkt_ready(p1_ready), .i_pkt_data(p1_data),
        .o_beat_valid(b1_valid), .i_beat_ready(b1_ready), .o_beat_data(b1_data),
        .o_beat_last(b1_last), .o_beat_index(b1_idx), .o_busy(b1_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: every accepted packet queues N beats; a beat leaves on handshake.
    always @(negedge clk) begin
        if (areset) begin
            q.delete();
        end else begin
            chk("mon_valid", beat_valid, q.size() != 0);
            chk("mon_busy", busy, q.size() != 0);
            if (busy) busy_cyc++;
            if (q.size() != 0) begin
                chk("mon_data", beat_data, q[0].d);
                chk("mon_last", beat_last, q[0].l);
                chk("mon_idx", beat_idx, q[0].i);
            end
            chk("mon_pkt_ready", pkt_ready,
                !flush && (q.size() == 0 || (q.size() == 1 && beat_ready)));
            if (flush) begin
                q.delete();
            end else begin
                if (beat_valid && beat_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    rx_cnt++;
                end
                if (pkt_valid && pkt_ready) begin
                    for (int k = 0; k < N; k++) begin
                        beat_t b;
                        b.d = pkt_data[k*W +: W];
                        b.l = (k == N - 1);
                        b.i = 3'(k);
                        q.push_back(b);
                    end
                end
            end
        end
    end

    initial begin
        areset = 1'b1; flush = 1'b0; pkt_valid = 1'b0; pkt_data = '0; beat_ready = 1'b1;
        f1 = 1'b0; p1_valid = 1'b0; p1_data = '0; b1_ready = 1'b1;
        #1;
        chk("rst_valid", beat_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last", beat_last, 1'b0);
        chk("rst_idx", beat_idx, 3'd0);
        chk("rst_data", beat_data, 32'h0);
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        #1 chk("rst_pkt_ready", pkt_ready, 1'b1);

        // Single-beat packets back to back: 0xA, 0xB, 0xC
        tick; p1_valid = 1'b1; p1_data = 8'h0A;
        @(negedge clk);
        chk("n1_idle_valid", b1_valid, 1'b0);
        chk("n1_idle_ready", p1_ready, 1'b1);
        tick; p1_data = 8'h0B;
        @(negedge clk);
        chk("n1_a_data", b1_data, 8'h0A);
        chk("n1_a_last", b1_last, 1'b1);
        chk("n1_a_idx", b1_idx, 1'b0);
        chk("n1_a_pkt_ready", p1_ready, 1'b1);
        tick; p1_data = 8'h0C;
        @(negedge clk);
        chk("n1_b_data", b1_data, 8'h0B);
        chk("n1_b_last", b1_last, 1'b1);
        chk("n1_b_valid", b1_valid, 1'b1);
        tick; p1_valid = 1'b0;
        @(negedge clk);
        chk("n1_c_data", b1_data, 8'h0C);
        chk("n1_c_last", b1_last, 1'b1);
        chk("n1_c_idx", b1_idx, 1'b0);
        tick;
        @(negedge clk);
        chk("n1_done_valid", b1_valid, 1'b0);

        // Single packet, continuous ready
        tick;
        r0 = rx_cnt; b0 = busy_cyc;
        pkt_valid = 1'b1; pkt_data = 128'h44444444_33333333_22222222_11111111;
        tick; pkt_valid = 1'b0;
        @(negedge clk);
        chk("s1_first_beat", beat_data, 32'h11111111);
        repeat (6) tick;
        chk("s1_beats", rx_cnt - r0, 4);
        chk("s1_busy_cycles", busy_cyc - b0, 4);

        // Backpressure on beat 1 for three cycles
        r0 = rx_cnt; b0 = busy_cyc;
        pkt_valid = 1'b1; pkt_data = {$urandom, $urandom, $urandom, $urandom};
        tick; pkt_valid = 1'b0;
        tick; beat_ready = 1'b0;
        @(negedge clk);
        chk("bp_hold_idx", beat_idx, 3'd1);
        repeat (3) tick;
        beat_ready = 1'b1;
        repeat (6) tick;
        chk("bp_beats", rx_cnt - r0, 4);
        chk("bp_busy_cycles", busy_cyc - b0, 7);

        // Back-to-back A then B with valid held
        r0 = rx_cnt; b0 = busy_cyc;
        pkt_valid = 1'b1; pkt_data = {$urandom, $urandom, $urandom, $urandom};
        tick; pkt_data = {$urandom, $urandom, $urandom, $urandom};
        repeat (4) tick;
        pkt_valid = 1'b0;
        repeat (6) tick;
        chk("b2b_beats", rx_cnt - r0, 8);
        chk("b2b_busy_cycles", busy_cyc - b0, 8);

        // Flush while beat 1 is on the bus, with a competing packet offer
        r0 = rx_cnt;
        pkt_valid = 1'b1; pkt_data = {$urandom, $urandom, $urandom, $urandom};
        tick; pkt_valid = 1'b0;
        tick;
        flush = 1'b1; pkt_valid = 1'b1;
        pkt_data = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
        @(negedge clk);
        chk("fl_pkt_ready", pkt_ready, 1'b0);
        tick; flush = 1'b0;
        @(negedge clk);
        chk("fl_valid_drop", beat_valid, 1'b0);
        tick; pkt_valid = 1'b0;
        @(negedge clk);
        chk("fl_new_data", beat_data, 32'h55555555);
        chk("fl_new_idx", beat_idx, 3'd0);
        repeat (6) tick;
        chk("fl_beats", rx_cnt - r0, 5);

        // Asynchronous reset during beat 2
        pkt_valid = 1'b1; pkt_data = {$urandom, $urandom, $urandom, $urandom};
        tick; pkt_valid = 1'b0;
        tick; tick;
        #2 areset = 1'b1;
        #1;
        chk("ar_valid", beat_valid, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_last", beat_last, 1'b0);
        chk("ar_idx", beat_idx, 3'd0);
        chk("ar_data", beat_data, 32'h0);
        @(posedge clk);
        #1 areset = 1'b0;
        #1 chk("ar_pkt_ready", pkt_ready, 1'b1);
        r0 = rx_cnt;
        pkt_valid = 1'b1; pkt_data = {$urandom, $urandom, $urandom, $urandom};
        tick; pkt_valid = 1'b0;
        repeat (6) tick;
        chk("ar_beats", rx_cnt - r0, 4);

        // Random traffic with occasional flushes
        for (int c = 0; c < 500; c++) begin
            pkt_valid  = ($urandom_range(0, 2) != 0);
            pkt_data   = {$urandom, $urandom, $urandom, $urandom};
            beat_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            tick;
        end
        pkt_valid = 1'b0; flush = 1'b0; beat_ready = 1'b1;
        repeat (8) tick;
        chk("drain_empty", q.size(), 0);
        chk("drain_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
